// File: rtl/alu_share_arb.sv
// Two-port arbiter/sequencer for the shared 16-bit LC-3b ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration (default: fixed priority to port 0).
module alu_share_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [15:0] req_a_0,
    input  logic [15:0] req_a_1,
    input  logic [15:0] req_b_0,
    input  logic [15:0] req_b_1,
    input  logic [1:0]  req_op_0,
    input  logic [1:0]  req_op_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [15:0] rsp_res_0,
    output logic [15:0] rsp_res_1,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_res,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   grant_0;
    logic   grant_1;

`ifdef ALU_ARB_RR_EN
    logic   ptr;

    // Grant in IDLE only; the pointer breaks ties between two valid requests
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (state == IDLE) begin
            grant_0 = req_valid_0 & (~req_valid_1 | ~ptr);
            grant_1 = req_valid_1 & (~req_valid_0 | ptr);
        end
    end

    // After a grant the pointer favours the requester that lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (grant_0) begin
            ptr <= 1'b1;
        end else if (grant_1) begin
            ptr <= 1'b0;
        end
    end
`else
    // Grant in IDLE only; port 0 always wins a tie
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (state == IDLE) begin
            grant_0 = req_valid_0;
            grant_1 = req_valid_1 & ~req_valid_0;
        end
    end
`endif

    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;
    assign busy        = (state != IDLE);

    // Sequencer: latch operands, run the ALU one cycle, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            alu_a       <= 16'h0000;
            alu_b       <= 16'h0000;
            alu_op      <= 2'b00;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_res_0   <= 16'h0000;
            rsp_res_1   <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_0) begin
                        alu_a  <= req_a_0;
                        alu_b  <= req_b_0;
                        alu_op <= req_op_0;
                        owner  <= 1'b0;
                        state  <= EXEC;
                    end else if (grant_1) begin
                        alu_a  <= req_a_1;
                        alu_b  <= req_b_1;
                        alu_op <= req_op_1;
                        owner  <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner) begin
                        rsp_res_1   <= alu_res;
                        rsp_valid_1 <= 1'b1;
                    end else begin
                        rsp_res_0   <= alu_res;
                        rsp_valid_0 <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (!owner && rsp_ready_0) begin
                        rsp_valid_0 <= 1'b0;
                        state       <= IDLE;
                    end else if (owner && rsp_ready_1) begin
                        rsp_valid_1 <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a behavioural ALU and reference model.
// Expectations follow ALU_ARB_RR_EN when it is defined for the build.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_0 = 1'b0;
    logic        req_valid_1 = 1'b0;
    logic        req_ready_0;
    logic        req_ready_1;
    logic [15:0] req_a_0 = '0;
    logic [15:0] req_a_1 = '0;
    logic [15:0] req_b_0 = '0;
    logic [15:0] req_b_1 = '0;
    logic [1:0]  req_op_0 = '0;
    logic [1:0]  req_op_1 = '0;
    logic        rsp_valid_0;
    logic        rsp_valid_1;
    logic        rsp_ready_0 = 1'b0;
    logic        rsp_ready_1 = 1'b0;
    logic [15:0] rsp_res_0;
    logic [15:0] rsp_res_1;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_res;
    logic        busy;

    int total = 0;
    int bad = 0;

    int          grant_q[$];
    int          rsp_port_q[$];
    logic [15:0] rsp_res_q[$];
    logic        ready1_seen = 1'b0;
    int          vld_cycles = 0;

    alu_share_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_0 (req_valid_0),
        .req_valid_1 (req_valid_1),
        .req_ready_0 (req_ready_0),
        .req_ready_1 (req_ready_1),
        .req_a_0     (req_a_0),
        .req_a_1     (req_a_1),
        .req_b_0     (req_b_0),
        .req_b_1     (req_b_1),
        .req_op_0    (req_op_0),
        .req_op_1    (req_op_1),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_ready_0 (rsp_ready_0),
        .rsp_ready_1 (rsp_ready_1),
        .rsp_res_0   (rsp_res_0),
        .rsp_res_1   (rsp_res_1),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_res     (alu_res),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_res = ref_alu(alu_a, alu_b, alu_op);

    always @(posedge clk) begin
        if (rst_n && req_valid_0 && req_ready_0) grant_q.push_back(0);
        if (rst_n && req_valid_1 && req_ready_1) grant_q.push_back(1);
        if (req_ready_1) ready1_seen <= 1'b1;
        if (rsp_valid_0 && rsp_ready_0) begin
            rsp_port_q.push_back(0);
            rsp_res_q.push_back(rsp_res_0);
        end
        if (rsp_valid_1 && rsp_ready_1) begin
            rsp_port_q.push_back(1);
            rsp_res_q.push_back(rsp_res_1);
        end
        if (rsp_valid_0 || rsp_valid_1) vld_cycles <= vld_cycles + 1;
    end

    task automatic set_req(input int p, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] op);
        if (p == 0) begin
            req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_op_0 = op;
        end else begin
            req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_op_1 = op;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives one request on port p and records what was observed along the way
    task automatic run_op(input int p, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input int hold,
                          output logic to, output logic [15:0] ea, output logic [15:0] eb,
                          output logic [1:0] eop, output logic vld, output logic [15:0] res,
                          output logic other, output logic stable, output logic idle,
                          output logic [15:0] res_after);
        int n = 0;
        to = 1'b0; stable = 1'b1;
        ea = '0; eb = '0; eop = '0; vld = 1'b0; res = '0;
        other = 1'b0; idle = 1'b0; res_after = '0;
        set_req(p, 1'b1, a, b, op);
        #1;
        while (!(p == 1 ? req_ready_1 : req_ready_0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            to = 1'b1;
            set_req(p, 1'b0, a, b, op);
            return;
        end
        @(posedge clk); #1;
        set_req(p, 1'b0, 16'h0, 16'h0, 2'b00);
        ea = alu_a; eb = alu_b; eop = alu_op;
        @(posedge clk); #1;
        vld   = (p == 1) ? rsp_valid_1 : rsp_valid_0;
        res   = (p == 1) ? rsp_res_1 : rsp_res_0;
        other = (p == 1) ? rsp_valid_0 : rsp_valid_1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (((p == 1) ? rsp_valid_1 : rsp_valid_0) !== 1'b1) stable = 1'b0;
            if (((p == 1) ? rsp_res_1 : rsp_res_0) !== res) stable = 1'b0;
            if (busy !== 1'b1 || req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) stable = 1'b0;
        end
        if (p == 1) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
        @(posedge clk); #1;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        idle = (busy === 1'b0) && (((p == 1) ? rsp_valid_1 : rsp_valid_0) === 1'b0);
        res_after = (p == 1) ? rsp_res_1 : rsp_res_0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=00000",
                     {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, busy});
        end
        total++;
        if ({rsp_res_0, rsp_res_1, alu_a, alu_b, alu_op} !== 66'b0) begin
            bad++;
            $display("FAIL reset_data got=%h %h %h %h %b want=0", rsp_res_0, rsp_res_1,
                     alu_a, alu_b, alu_op);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_valid got=%b%b%b want=000", req_ready_0, req_ready_1, busy);
        end
    endtask

    task automatic test_add_overflow();
        logic to, vld, other, stable, idle;
        logic [15:0] ea, eb, res, res_after;
        logic [1:0] eop;
        run_op(0, 16'h7FFF, 16'h0001, 2'b00, 0, to, ea, eb, eop, vld, res, other,
               stable, idle, res_after);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL add_timeout got=1 want=0"); end
        total++;
        if (ea !== 16'h7FFF || eb !== 16'h0001 || eop !== 2'b00) begin
            bad++;
            $display("FAIL add_exec_alu got=%h %h %b want=7fff 0001 00", ea, eb, eop);
        end
        total++;
        if (vld !== 1'b1 || res !== 16'h8000) begin
            bad++;
            $display("FAIL add_rsp got=%b %h want=1 8000", vld, res);
        end
        total++;
        if (other !== 1'b0) begin bad++; $display("FAIL add_other_vld got=%b want=0", other); end
        total++;
        if (idle !== 1'b1 || res_after !== 16'h8000) begin
            bad++;
            $display("FAIL add_done got=%b %h want=1 8000", idle, res_after);
        end
    endtask

    task automatic test_port1_wrap_xor();
        logic to, vld, other, stable, idle;
        logic [15:0] ea, eb, res, res_after;
        logic [1:0] eop;
        run_op(1, 16'hFFFF, 16'h0001, 2'b00, 0, to, ea, eb, eop, vld, res, other,
               stable, idle, res_after);
        total++;
        if (to !== 1'b0 || vld !== 1'b1 || res !== 16'h0000 || other !== 1'b0) begin
            bad++;
            $display("FAIL p1_wrap got=%b %b %h %b want=0 1 0000 0", to, vld, res, other);
        end
        @(posedge clk); #1;
        run_op(1, 16'hA5A5, 16'hFFFF, 2'b10, 0, to, ea, eb, eop, vld, res, other,
               stable, idle, res_after);
        total++;
        if (to !== 1'b0 || vld !== 1'b1 || res !== 16'h5A5A || eop !== 2'b10) begin
            bad++;
            $display("FAIL p1_xor got=%b %b %h %b want=0 1 5a5a 10", to, vld, res, eop);
        end
        total++;
        if (idle !== 1'b1 || res_after !== 16'h5A5A) begin
            bad++;
            $display("FAIL p1_hold_after got=%b %h want=1 5a5a", idle, res_after);
        end
    endtask

    task automatic test_contention();
        int n = 0;
        int want_port;
        pulse_reset();
        grant_q.delete(); rsp_port_q.delete(); rsp_res_q.delete();
        ready1_seen = 1'b0;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        set_req(0, 1'b1, 16'hF0F0, 16'h0FF0, 2'b01);
        set_req(1, 1'b1, 16'h1234, 16'hBEEF, 2'b11);
        while (grant_q.size() < 4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        set_req(0, 1'b0, 16'h0, 16'h0, 2'b00);
        set_req(1, 1'b0, 16'h0, 16'h0, 2'b00);
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        total++;
        if (grant_q.size() != 4 || rsp_port_q.size() != 4) begin
            bad++;
            $display("FAIL cont_count got=%0d/%0d want=4/4", grant_q.size(), rsp_port_q.size());
            return;
        end
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            want_port = (i == 0) ? 0 : 1 - grant_q[i-1];
`else
            want_port = 0;
`endif
            total++;
            if (grant_q[i] != want_port) begin
                bad++;
                $display("FAIL cont_grant%0d got=%0d want=%0d", i, grant_q[i], want_port);
            end
            total++;
            if (rsp_port_q[i] != want_port ||
                rsp_res_q[i] !== (want_port == 0 ? ref_alu(16'hF0F0, 16'h0FF0, 2'b01)
                                                 : ref_alu(16'h1234, 16'hBEEF, 2'b11))) begin
                bad++;
                $display("FAIL cont_rsp%0d got=p%0d %h want=p%0d", i, rsp_port_q[i],
                         rsp_res_q[i], want_port);
            end
        end
`ifndef ALU_ARB_RR_EN
        total++;
        if (ready1_seen !== 1'b0) begin
            bad++;
            $display("FAIL cont_ready1 got=%b want=0", ready1_seen);
        end
`endif
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [15:0] want;
        want = ref_alu(16'h1357, 16'h2468, 2'b00);
        set_req(0, 1'b1, 16'h1357, 16'h2468, 2'b00);
        #1;
        while (!req_ready_0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h0, 16'h0, 2'b00);
        @(posedge clk); #1;
        set_req(1, 1'b1, 16'h0001, 16'h0001, 2'b00);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rsp_valid_0 !== 1'b1 || rsp_res_0 !== want || busy !== 1'b1 ||
                req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got=%b %h %b %b%b want=1 %h 1 00", i, rsp_valid_0,
                         rsp_res_0, busy, req_ready_0, req_ready_1, want);
            end
            @(posedge clk); #1;
        end
        rsp_ready_0 = 1'b1;
        set_req(1, 1'b0, 16'h0, 16'h0, 2'b00);
        @(posedge clk); #1;
        rsp_ready_0 = 1'b0;
        total++;
        if (busy !== 1'b0 || rsp_valid_0 !== 1'b0 || rsp_res_0 !== want) begin
            bad++;
            $display("FAIL bp_release got=%b %b %h want=0 0 %h", busy, rsp_valid_0,
                     rsp_res_0, want);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        for (int phase = 0; phase < 2; phase++) begin
            n = 0;
            set_req(0, 1'b1, 16'hAAAA, 16'h5555, 2'b11);
            #1;
            while (!req_ready_0 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            @(posedge clk); #1;
            set_req(0, 1'b0, 16'h0, 16'h0, 2'b00);
            if (phase == 1) begin
                @(posedge clk); #1;
                total++;
                if (rsp_valid_0 !== 1'b1 || rsp_res_0 !== 16'hAAAA) begin
                    bad++;
                    $display("FAIL rstmid_pre got=%b %h want=1 aaaa", rsp_valid_0, rsp_res_0);
                end
            end
            rst_n = 1'b0;
            #1;
            total++;
            if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0 || busy !== 1'b0 ||
                alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 2'b00 || rsp_res_0 !== 16'h0) begin
                bad++;
                $display("FAIL rstmid_async%0d got=%b %b %h %h %b %h want=0 0 0 0 00 0", phase,
                         rsp_valid_0, busy, alu_a, alu_b, alu_op, rsp_res_0);
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
            vld_cycles = 0;
            repeat (6) @(posedge clk);
            #1;
            total++;
            if (vld_cycles != 0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_after%0d got=%0d %b want=0 0", phase, vld_cycles, busy);
            end
        end
    endtask

    task automatic test_random();
        logic to, vld, other, stable, idle;
        logic [15:0] ea, eb, res, res_after, a, b, want;
        logic [1:0] eop, op;
        int p, hold;
        for (int i = 0; i < 16; i++) begin
            p    = int'($urandom_range(0, 1));
            a    = 16'($urandom);
            b    = 16'($urandom);
            op   = 2'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 3));
            want = ref_alu(a, b, op);
            run_op(p, a, b, op, hold, to, ea, eb, eop, vld, res, other, stable, idle,
                   res_after);
            total++;
            if (to !== 1'b0 || ea !== a || eb !== b || eop !== op) begin
                bad++;
                $display("FAIL rnd%0d_exec got=%b %h %h %b want=0 %h %h %b", i, to, ea, eb,
                         eop, a, b, op);
            end
            total++;
            if (vld !== 1'b1 || res !== want || other !== 1'b0 || stable !== 1'b1 ||
                idle !== 1'b1 || res_after !== want) begin
                bad++;
                $display("FAIL rnd%0d_rsp p=%0d got=%b %h %b %b %b %h want=1 %h 0 1 1", i, p,
                         vld, res, other, stable, idle, res_after, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        @(posedge clk); #1;
        test_port1_wrap_xor();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
